bf16_vec_sequencer: RTL
=======================

Name: bf16_vec_sequencer

Overview:
- Command-driven sequencer placed directly upstream of BF16Unit (combinational, io_opc[2:0]/io_a/io_b -> io_y).
- Accepts one vector command: opcode, two source base addresses, one destination base address and a length.
- Streams operand pairs from two scratchpad read ports into BF16Unit, one pair per cycle. Writes each result back through a registered write port, then pulses done.

Parameters:
ADDR_W, 10, scratchpad address width; all address arithmetic is modulo 2^ADDR_W
LEN_W, 10, width of the element-count field

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
io_cmd_valid  in  1  command offered
io_cmd_ready  out  1  command accepted when valid&ready
io_cmd_opc  in  3  BF16Unit opcode (000 add, 001 sub, 010 mul; others passed through)
io_cmd_srcA  in  ADDR_W  operand A base
io_cmd_srcB  in  ADDR_W  operand B base
io_cmd_dst  in  ADDR_W  result base
io_cmd_len  in  LEN_W  element count
io_rdA_en  out  1  read strobe, port A
io_rdA_addr  out  ADDR_W  read address, port A
io_rdA_data  in  16  read data, valid exactly 1 cycle after strobe
io_rdB_en / io_rdB_addr / io_rdB_data  same as port A, for operand B
io_alu_opc  out  3  to BF16Unit io_opc
io_alu_a  out  16  to BF16Unit io_a
io_alu_b  out  16  to BF16Unit io_b
io_alu_y  in  16  from BF16Unit io_y
io_wr_en  out  1  write strobe
io_wr_addr  out  ADDR_W  write address
io_wr_data  out  16  write data
io_busy  out  1  high from the cycle after accept until done
io_done  out  1  single-cycle completion pulse

Behaviour:
- Reset, and the first cycle after reset:
  - io_cmd_ready=0 while reset is high; 1 in the first cycle after reset falls.
  - All other outputs are 0; state=IDLE; counters=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - io_cmd_ready=1.
  - On valid&ready at cycle T, latch opc, srcA, srcB, dst and len.
  - len!=0: go to RUN at T+1.
  - len==0: go to DONE at T+1. No reads or writes occur.
- RUN, issue index k = 0..len-1, cycle T+1+k:
  - rdA_en=rdB_en=1.
  - rdA_addr=(srcA+k) mod 2^ADDR_W; rdB_addr=(srcB+k) mod 2^ADDR_W.
  - After issuing k=len-1, go to DRAIN.
- Datapath:
  - io_alu_a=io_rdA_data and io_alu_b=io_rdB_data, combinationally.
  - io_alu_opc=latched opc, held constant throughout the command.
  - The cycle after read k, register io_alu_y into io_wr_data.
  - Assert io_wr_en with io_wr_addr=(dst+k) mod 2^ADDR_W.
  - Result: write k appears at cycle T+3+k.
- DRAIN: lasts until the final write (T+2+len) has been presented.
- DONE:
  - io_done=1 for exactly one cycle, at T+3+len (T+1 when len==0).
  - State returns to IDLE the next cycle.
- io_busy is high from T+1 through the DONE cycle inclusive.
- io_wr_en is 0 whenever no result is pending. io_wr_addr and io_wr_data hold their last values when io_wr_en=0.
- While not in IDLE, io_cmd_ready=0 and io_cmd_valid is ignored. A command held valid is accepted in the first IDLE cycle after DONE.
- Address wrap: srcA/srcB/dst + k wraps to 0 past 2^ADDR_W-1. No error is raised.
- Overlapping dst and src regions: there is no hazard check. Read k is always issued before write k; later reads observe earlier writes only per memory semantics.
- Reset mid-operation: abort immediately. Pending writes are dropped, no done pulse is issued, and the block is in IDLE the cycle after reset falls.
- Maximum len=2^LEN_W-1. The index counter is LEN_W bits wide and never wraps within one command.

Test Plan:
1. Add: opc=000, len=1, mem A[0]=0x41cc, B[0]=0x41ac, dst=0x020, with real BF16Unit attached -> one write {0x020, 0x423c} at T+3; done at T+4; busy T+1..T+4.
2. Sub then mul, issued back-to-back with cmd_valid held: opc=001 then 010, same operands -> writes 0x4080 then 0x4409. Second accept occurs in the IDLE cycle after the first done.
3. Stream: len=4, srcA=0x000, srcB=0x100, dst=0x200, opc=000, A[i]=B[i]=0x3f80 -> 4 consecutive writes of 0x4000 to 0x200..0x203 at T+3..T+6; done at T+7.
4. Zero length: len=0 -> no rd_en or wr_en ever asserted; done at T+1; ready back at T+2.
5. Wrap: ADDR_W=10, dst=0x3FF, srcA=0x3FE, len=3 -> read addresses 0x3FE, 0x3FF, 0x000; write addresses 0x3FF, 0x000, 0x001.
6. Reset at T+4 of a len=8 command -> no further writes, no done pulse, io_cmd_ready=1 in the cycle after reset falls, and a new command completes normally.

Source files
------------

// File: rtl/bf16_vec_sequencer.sv
// bf16_vec_sequencer
//   Accepts one vector command and streams operand pairs from two scratchpad
//   read ports through an external combinational BF16 unit. Each result is
//   registered and written back to the scratchpad. A single-cycle done pulse
//   ends the command.
//
// Ports
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   io_cmd_*                      valid/ready command: opc, srcA, srcB, dst, len
//   io_rdA_*, io_rdB_*            read strobes/addresses; data returns 1 cycle later
//   io_alu_opc/a/b, io_alu_y      connection to the combinational BF16 unit
//   io_wr_en/addr/data            registered write-back port
//   io_busy                       high from the cycle after accept through done
//   io_done                       one-cycle completion pulse
//
// Pipeline per element k (command accepted at cycle T):
//   T+1+k  read issued      T+2+k  data at BF16 unit      T+3+k  write presented
module bf16_vec_sequencer #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_cmd_valid,
  output logic              io_cmd_ready,
  input  logic [2:0]        io_cmd_opc,
  input  logic [ADDR_W-1:0] io_cmd_srcA,
  input  logic [ADDR_W-1:0] io_cmd_srcB,
  input  logic [ADDR_W-1:0] io_cmd_dst,
  input  logic [LEN_W-1:0]  io_cmd_len,
  output logic              io_rdA_en,
  output logic [ADDR_W-1:0] io_rdA_addr,
  input  logic [15:0]       io_rdA_data,
  output logic              io_rdB_en,
  output logic [ADDR_W-1:0] io_rdB_addr,
  input  logic [15:0]       io_rdB_data,
  output logic [2:0]        io_alu_opc,
  output logic [15:0]       io_alu_a,
  output logic [15:0]       io_alu_b,
  input  logic [15:0]       io_alu_y,
  output logic              io_wr_en,
  output logic [ADDR_W-1:0] io_wr_addr,
  output logic [15:0]       io_wr_data,
  output logic              io_busy,
  output logic              io_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [2:0]        opc_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  idx_reg;
  logic [ADDR_W-1:0] src_ptr_reg [2];
  logic [ADDR_W-1:0] src_base [2];
  logic [ADDR_W-1:0] dst_ptr_reg;
  logic              rd_pend_reg;    // a read was issued last cycle: its data is at the ALU now
  logic [ADDR_W-1:0] pend_addr_reg;  // destination address travelling with that read
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [15:0]       wr_data_reg;

  logic accept;
  logic issue;
  logic last_issue;

  assign accept     = io_cmd_valid && io_cmd_ready;
  assign issue      = (state_reg == RUN);
  assign last_issue = issue && (idx_reg == (len_reg - LEN_W'(1)));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Strobes and handshake are masked by reset so that an abort takes effect
  // in the very cycle reset is raised, not one cycle later.
  always_comb begin
    state_next   = state_reg;
    io_cmd_ready = 1'b0;
    io_busy      = 1'b0;
    io_done      = 1'b0;
    io_rdA_en    = 1'b0;
    io_rdB_en    = 1'b0;
    case (state_reg)
      IDLE: begin
        io_cmd_ready = !reset;
        if (io_cmd_valid) begin
          state_next = (io_cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        io_busy   = !reset;
        io_rdA_en = !reset;
        io_rdB_en = !reset;
        if (last_issue) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        io_busy = !reset;
        // Once no read is in flight, the last write is on the port this cycle.
        if (!rd_pend_reg) begin
          state_next = DONE;
        end
      end
      DONE: begin
        io_busy    = !reset;
        io_done    = !reset;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- source pointers
  assign src_base[0] = io_cmd_srcA;
  assign src_base[1] = io_cmd_srcB;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_ptr
      always_ff @(posedge clock) begin
        if (reset) begin
          src_ptr_reg[gi] <= '0;
        end else if (accept) begin
          src_ptr_reg[gi] <= src_base[gi];
        end else if (issue) begin
          src_ptr_reg[gi] <= src_ptr_reg[gi] + ADDR_W'(1);  // wraps modulo 2^ADDR_W
        end
      end
    end
  endgenerate

  assign io_rdA_addr = src_ptr_reg[0];
  assign io_rdB_addr = src_ptr_reg[1];

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      opc_reg       <= '0;
      len_reg       <= '0;
      idx_reg       <= '0;
      dst_ptr_reg   <= '0;
      rd_pend_reg   <= 1'b0;
      pend_addr_reg <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      if (accept) begin
        opc_reg     <= io_cmd_opc;
        len_reg     <= io_cmd_len;
        idx_reg     <= '0;
        dst_ptr_reg <= io_cmd_dst;
      end else if (issue) begin
        idx_reg     <= idx_reg + LEN_W'(1);
        dst_ptr_reg <= dst_ptr_reg + ADDR_W'(1);
      end

      rd_pend_reg <= issue;
      if (issue) begin
        pend_addr_reg <= dst_ptr_reg;
      end

      // Address and data hold their last values between writes.
      wr_en_reg <= rd_pend_reg;
      if (rd_pend_reg) begin
        wr_addr_reg <= pend_addr_reg;
        wr_data_reg <= io_alu_y;
      end
    end
  end

  assign io_alu_opc = opc_reg;
  assign io_alu_a   = io_rdA_data;
  assign io_alu_b   = io_rdB_data;
  assign io_wr_en   = wr_en_reg && !reset;
  assign io_wr_addr = wr_addr_reg;
  assign io_wr_data = wr_data_reg;

endmodule
